// File: rtl/pipe_regfile.sv
// Pipeline register file: zero-latency reads with write-through bypass,
// a per-register busy scoreboard, and a sequential clear after reset.
module pipe_regfile #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       RegWrite,
    input  logic [$clog2(NREGS)-1:0]   rd,
    input  logic [XLEN-1:0]            write_data,
    input  logic [$clog2(NREGS)-1:0]   rs1,
    input  logic [$clog2(NREGS)-1:0]   rs2,
    input  logic                       busy_set,
    input  logic [$clog2(NREGS)-1:0]   busy_rd,
    output logic [XLEN-1:0]            read_data1,
    output logic [XLEN-1:0]            read_data2,
    output logic                       busy1,
    output logic                       busy2,
    output logic                       ready
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     idx_q;
    logic              ready_q;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic run;
    logic wr_en;
    logic set_en;
    logic zero1;
    logic zero2;

    assign run    = (state_q == RUN);
    assign wr_en  = run && RegWrite && !((ZERO_REG != 0) && (rd == '0));
    assign set_en = run && busy_set && !((ZERO_REG != 0) && (busy_rd == '0));
    assign zero1  = (ZERO_REG != 0) && (rs1 == '0);
    assign zero2  = (ZERO_REG != 0) && (rs2 == '0);
    assign ready  = ready_q;

    // Clear is applied before set so a same-edge issue to the same register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (run && RegWrite) begin
            busy_d[rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[busy_rd] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    idx_q  <= idx_q + 1'b1;
                    busy_q <= '0;
                    if (idx_q == LAST_IDX) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    busy_q <= busy_d;
                end
                default: begin
                    state_q <= CLEAR;
                    idx_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; the CLEAR walk zeroes it instead.
    always_ff @(posedge CLK) begin
        if (state_q == CLEAR) begin
            mem_q[idx_q] <= '0;
        end else if (wr_en) begin
            mem_q[rd] <= write_data;
        end
    end

    always_comb begin
        read_data1 = '0;
        busy1      = 1'b0;
        if (run && !zero1) begin
            if (wr_en && (rd == rs1)) begin
                read_data1 = write_data;
            end else begin
                read_data1 = mem_q[rs1];
                busy1      = busy_q[rs1];
            end
        end
    end

    always_comb begin
        read_data2 = '0;
        busy2      = 1'b0;
        if (run && !zero2) begin
            if (wr_en && (rd == rs2)) begin
                read_data2 = write_data;
            end else begin
                read_data2 = mem_q[rs2];
                busy2      = busy_q[rs2];
            end
        end
    end

endmodule

// File: tb/tb_pipe_regfile.sv
// Randomised and directed bench for pipe_regfile against an array-based reference model.
module tb_pipe_regfile;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            RegWrite = 1'b0;
    logic [4:0]      rd = '0;
    logic [63:0]     write_data = '0;
    logic [4:0]      rs1 = '0;
    logic [4:0]      rs2 = '0;
    logic            busy_set = 1'b0;
    logic [4:0]      busy_rd = '0;
    logic [63:0]     read_data1;
    logic [63:0]     read_data2;
    logic            busy1;
    logic            busy2;
    logic            ready;

    int total = 0;
    int bad   = 0;

    bit [63:0] m_mem  [NREGS];
    bit        m_busy [NREGS];
    bit        m_run;
    int        m_cnt;

    pipe_regfile #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
        .CLK(CLK), .RST(RST), .RegWrite(RegWrite), .rd(rd),
        .write_data(write_data), .rs1(rs1), .rs2(rs2),
        .busy_set(busy_set), .busy_rd(busy_rd),
        .read_data1(read_data1), .read_data2(read_data2),
        .busy1(busy1), .busy2(busy2), .ready(ready)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_run = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    endtask

    task automatic model_edge();
        if (RST) begin
            model_reset();
        end else if (!m_run) begin
            m_cnt++;
            if (m_cnt == NREGS) begin
                m_run = 1'b1;
                for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
            end
        end else begin
            if (RegWrite) begin
                if (rd != 0) m_mem[rd] = write_data;
                m_busy[rd] = 1'b0;
            end
            if (busy_set && busy_rd != 0) m_busy[busy_rd] = 1'b1;
        end
    endtask

    function automatic logic [63:0] exp_data(input logic [4:0] rs);
        if (!m_run || rs == 0) return '0;
        if (RegWrite && rd == rs) return write_data;
        return m_mem[rs];
    endfunction

    function automatic logic exp_busy(input logic [4:0] rs);
        if (!m_run || rs == 0) return 1'b0;
        if (RegWrite && rd == rs) return 1'b0;
        return m_busy[rs];
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0; busy_set = 1'b0;
        rd = '0; busy_rd = '0; write_data = '0;
    endtask

    task automatic assert_reset();
        RST = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rs1 = 5'd5; rs2 = 5'd5;
        assert_reset();
        total++;
        if (ready !== 1'b0 || read_data1 !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals ready=%b rd1=%h b1=%b b2=%b exp 0", ready, read_data1, busy1, busy2);
        end
        release_reset();
        for (int e = 1; e <= NREGS; e++) begin
            tick();
            total++;
            if (ready !== ((e == NREGS) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL ready_edge e=%0d got=%b exp=%b", e, ready, (e == NREGS));
            end
        end
        total++;
        if (read_data1 !== 64'd0) begin
            bad++;
            $display("FAIL post_clear_r5 got=%h exp=0", read_data1);
        end
    endtask

    task automatic test_clear_drop();
        idle();
        assert_reset();
        release_reset();
        rs1 = 5'd3;
        for (int e = 1; e <= NREGS; e++) begin
            RegWrite = 1'b1; rd = 5'd3; write_data = 64'hFF;
            busy_set = 1'b1; busy_rd = 5'd3;
            #1;
            if (e <= 3) begin
                total++;
                if (read_data1 !== 64'd0 || busy1 !== 1'b0) begin
                    bad++;
                    $display("FAIL clear_outputs e=%0d rd1=%h b1=%b exp 0", e, read_data1, busy1);
                end
            end
            tick();
        end
        idle();
        #1;
        total++;
        if (ready !== 1'b1 || read_data1 !== 64'd0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL clear_drop ready=%b rd1=%h b1=%b exp 1/0/0", ready, read_data1, busy1);
        end
    endtask

    task automatic test_bypass();
        idle();
        RegWrite = 1'b1; rd = 5'd7; write_data = 64'hDEAD_BEEF; rs1 = 5'd7;
        #1;
        total++;
        if (read_data1 !== 64'hDEAD_BEEF) begin
            bad++;
            $display("FAIL bypass_same got=%h exp=deadbeef", read_data1);
        end
        tick();
        idle();
        #1;
        total++;
        if (read_data1 !== 64'hDEAD_BEEF || read_data1 !== exp_data(rs1)) begin
            bad++;
            $display("FAIL bypass_after got=%h exp=deadbeef", read_data1);
        end
    endtask

    task automatic test_zero();
        idle();
        RegWrite = 1'b1; rd = 5'd0; write_data = 64'h55; rs2 = 5'd0;
        busy_set = 1'b1; busy_rd = 5'd0;
        #1;
        total++;
        if (read_data2 !== 64'd0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL zero_same rd2=%h b2=%b exp 0", read_data2, busy2);
        end
        tick();
        idle();
        #1;
        total++;
        if (read_data2 !== 64'd0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL zero_after rd2=%h b2=%b exp 0", read_data2, busy2);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        busy_set = 1'b1; busy_rd = 5'd9;
        tick();
        idle();
        rs1 = 5'd9; rs2 = 5'd9;
        #1;
        total++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            bad++;
            $display("FAIL sb_set b1=%b b2=%b exp 1", busy1, busy2);
        end
        RegWrite = 1'b1; rd = 5'd9; write_data = 64'h77;
        busy_set = 1'b1; busy_rd = 5'd9;
        tick();
        idle();
        #1;
        total++;
        if (busy1 !== 1'b1) begin
            bad++;
            $display("FAIL sb_set_wins b1=%b exp 1", busy1);
        end
        RegWrite = 1'b1; rd = 5'd9; write_data = 64'h88;
        tick();
        idle();
        #1;
        total++;
        if (busy1 !== 1'b0 || read_data1 !== 64'h88) begin
            bad++;
            $display("FAIL sb_clear b1=%b rd1=%h exp 0/88", busy1, read_data1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            RegWrite   = ($urandom_range(0, 1) == 1);
            rd         = 5'($urandom_range(0, NREGS - 1));
            write_data = {$urandom, $urandom};
            busy_set   = ($urandom_range(0, 2) == 0);
            busy_rd    = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, NREGS - 1));
            rs1        = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, NREGS - 1));
            rs2        = ($urandom_range(0, 4) == 0) ? rs1 : 5'($urandom_range(0, NREGS - 1));
            #1;
            total++;
            if (read_data1 !== exp_data(rs1) || busy1 !== exp_busy(rs1)) begin
                bad++;
                $display("FAIL rand_p1 c=%0d rs1=%0d got=%h/%b exp=%h/%b",
                         c, rs1, read_data1, busy1, exp_data(rs1), exp_busy(rs1));
            end
            total++;
            if (read_data2 !== exp_data(rs2) || busy2 !== exp_busy(rs2)) begin
                bad++;
                $display("FAIL rand_p2 c=%0d rs2=%0d got=%h/%b exp=%h/%b",
                         c, rs2, read_data2, busy2, exp_data(rs2), exp_busy(rs2));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midclear();
        idle();
        RegWrite = 1'b1; rd = 5'd20; write_data = 64'h1234;
        tick();
        idle();
        rs1 = 5'd20;
        #1;
        total++;
        if (read_data1 !== 64'h1234) begin
            bad++;
            $display("FAIL pre_reset_r20 got=%h exp=1234", read_data1);
        end
        assert_reset();
        release_reset();
        for (int e = 0; e < 10; e++) tick();
        assert_reset();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL midclear_ready got=%b exp=0", ready);
        end
        release_reset();
        for (int e = 1; e <= NREGS; e++) begin
            tick();
            if (e >= NREGS - 1) begin
                total++;
                if (ready !== ((e == NREGS) ? 1'b1 : 1'b0)) begin
                    bad++;
                    $display("FAIL midclear_edge e=%0d got=%b exp=%b", e, ready, (e == NREGS));
                end
            end
        end
        total++;
        if (read_data1 !== 64'd0) begin
            bad++;
            $display("FAIL midclear_r20 got=%h exp=0", read_data1);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clear_drop();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_random();
        test_reset_midclear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
